// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/kill request, operands and result handshake of the multiply/divide unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic start;
  logic kill;
  logic [2:0] funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic ready;
  logic done;
  logic [WIDTH-1:0] result;
  modport master(output start, kill, funct3, a, b, input ready, done, result);
  modport slave(input start, kill, funct3, a, b, output ready, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic [WIDTH-1:0] m, res, a, b, ma, mb, q_fix, r_fix, res_n;
  logic [2*WIDTH-1:0] p, prod, mul_next, div_next;
  logic [WIDTH:0] mul_sum, rem_sh, diff;
  logic neg1, neg2, done_q, is_div, sa, sb, dz, ov, bypass;
  assign a = bus.a;
  assign b = bus.b;
  assign is_div = bus.funct3[2];
  assign sa = a[WIDTH-1] & (is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10));
  assign sb = b[WIDTH-1] & (is_div ? ~bus.funct3[0] : bus.funct3[1:0] == 2'b01);
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign dz = is_div && b == '0;
  assign ov = is_div && !bus.funct3[0] && a == MIN && b == '1;
  assign bypass = dz | ov;
  // p holds {high, low}: product accumulator for multiply, {remainder, quotient} for divide
  assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign mul_next = {mul_sum, p[WIDTH-1:1]};
  assign rem_sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign diff = rem_sh - {1'b0, m};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  assign prod = neg1 ? -p : p;
  assign q_fix = neg1 ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign r_fix = neg2 ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  assign res_n = op[2] ? (op[1] ? r_fix : q_fix) : (op[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
  assign bus.ready = state == IDLE;
  assign bus.done = done_q;
  assign bus.result = res;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      m <= '0;
      p <= '0;
      neg1 <= 1'b0;
      neg2 <= 1'b0;
      res <= '0;
      done_q <= 1'b0;
    end else if (bus.kill) begin
      state <= IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          op <= bus.funct3;
          cnt <= '0;
          m <= is_div ? mb : ma;
          neg1 <= (sa ^ sb) & ~bypass;
          neg2 <= is_div & sa & ~bypass;
          // special cases preload p so FINISH yields the architected value with no sign fix
          p <= dz ? {a, {WIDTH{1'b1}}} : ov ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, is_div ? ma : mb};
          state <= bypass ? FINISH : CALC;
        end
      end else if (state == CALC) begin
        p <= op[2] ? div_next : mul_next;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH-1)) state <= FINISH;
      end else begin
        res <= res_n;
        done_q <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  typedef struct {logic [W-1:0] res; int acc; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] last_res = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic void chk(input string n, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endfunction

  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic signed [W-1:0] sa, sb, sr;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MIN && b == '1) return a;
        sr = sa / sb;
        return sr;
      end
      3'd5: return b == 0 ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == '1) return '0;
        sr = sa % sb;
        return sr;
      end
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic bit special(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    return f[2] && (b == 0 || (!f[0] && a == MIN && b == '1));
  endfunction

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    int t = 0;
    @(negedge clk);
    while (!bus.ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: ready=%b expected 1", bus.ready);
    end
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.a = a;
    bus.b = b;
    if (track) q.push_back('{model(f, a, b), cyc + 1, special(f, a, b) ? 1 : W + 1});
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((q.size() != 0 || !bus.ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || !bus.ready) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: pending=%0d ready=%b expected 0 and 1", q.size(), bus.ready);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return MIN;
      2: return '1;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_done: result=%h expected no done", bus.result);
      end else begin
        e = q.pop_front();
        chk("result", bus.result, e.res);
        chk("latency", W'(cyc - e.acc), W'(e.lat));
        last_res = e.res;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.funct3 = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", W'(bus.ready), 1);
    chk("reset_done", W'(bus.done), 0);
    chk("reset_result", bus.result, 0);
    rst_n = 1'b1;
    // directed ops issued back-to-back: each new start lands in the previous done cycle
    issue(3'd0, 7, 32'hFFFF_FFFD, 1);
    issue(3'd1, MIN, MIN, 1);
    issue(3'd2, '1, '1, 1);
    issue(3'd3, '1, '1, 1);
    issue(3'd4, 32'hFFFF_FFF9, 2, 1);
    issue(3'd6, 32'hFFFF_FFF9, 2, 1);
    issue(3'd5, 100, 7, 1);
    issue(3'd7, 100, 7, 1);
    issue(3'd5, 5, 0, 1);
    issue(3'd6, 5, 0, 1);
    issue(3'd4, MIN, '1, 1);
    issue(3'd6, MIN, '1, 1);
    wait_idle();
    issue(3'd0, 32'h1234, 32'h5678, 0);
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.kill = 1'b0;
    @(negedge clk);
    chk("kill_ready", W'(bus.ready), 1);
    chk("kill_result", bus.result, last_res);
    repeat (40) @(negedge clk);
    chk("kill_result_held", bus.result, last_res);
    issue(3'd5, 9, 3, 1);
    wait_idle();
    issue(3'd4, 32'h100, 3, 0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_ready", W'(bus.ready), 1);
    chk("midreset_result", bus.result, 0);
    chk("midreset_done", W'(bus.done), 0);
    last_res = '0;
    repeat (40) @(negedge clk);
    issue(3'd7, 100, 7, 1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'd0;
    bus.a = 3;
    bus.b = 3;
    repeat (15) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    bus.start = 1'b1;
    bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.kill = 1'b0;
    @(negedge clk);
    chk("kill_blocks_accept", W'(bus.ready), 1);
    repeat (40) @(negedge clk);
    repeat (60) issue(3'($urandom_range(0, 7)), pick(), pick(), 1);
    wait_idle();
    chk("queue_drained", W'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
